// File: rtl/fifo_sync_thresh.sv
// ---- fifo_sync_thresh | synchronous FIFO with occupancy thresholds, sticky errors, optional FWFT | rev 1.0 ----
`default_nettype none

module fifo_sync_thresh #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clear_errors
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_AF    = LW'(AF_THRESH);
  localparam logic [LW-1:0] C_AE    = LW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          overflow_q, underflow_q;
  logic          wr_acc, rd_acc;

  // Flags gate acceptance independently: no pass-through when full, no bypass when empty.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_d;
      // Flags derive from the next level so they change on the same edge as level.
      full_q   <= (level_d == C_DEPTH);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= C_AF);
      aempty_q <= (level_d <= C_AE);
      overflow_q  <= (wr_en && full_q)  || (overflow_q  && !clear_errors);
      underflow_q <= (rd_en && empty_q) || (underflow_q && !clear_errors);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data = mem[rd_ptr_q];
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_thresh.sv
// ---- tb_fifo_sync_thresh | directed bench for fifo_sync_thresh, registered and FWFT instances | rev 1.0 ----
`default_nettype none

module tb_fifo_sync_thresh;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] wr_data;
  logic       wr_en, rd_en, clear_errors;

  logic       full_r, afull_r, empty_r, aempty_r, ovf_r, unf_r;
  logic [7:0] rdata_r;
  logic [2:0] level_r;
  logic       full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
  logic [7:0] rdata_f;
  logic [2:0] level_f;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fifo_sync_thresh #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0)) u_reg (
    .clock(clock), .resetn(resetn), .wr_data(wr_data), .wr_en(wr_en),
    .full(full_r), .almost_full(afull_r), .rd_en(rd_en), .rd_data(rdata_r),
    .empty(empty_r), .almost_empty(aempty_r), .level(level_r),
    .overflow(ovf_r), .underflow(unf_r), .clear_errors(clear_errors)
  );

  fifo_sync_thresh #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
    .clock(clock), .resetn(resetn), .wr_data(wr_data), .wr_en(wr_en),
    .full(full_f), .almost_full(afull_f), .rd_en(rd_en), .rd_data(rdata_f),
    .empty(empty_f), .almost_empty(aempty_f), .level(level_f),
    .overflow(ovf_f), .underflow(unf_f), .clear_errors(clear_errors)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {level, full, almost_full, empty, almost_empty, overflow, underflow}.
  task automatic check_flags(input string tag, input logic [2:0] lvl, input logic [5:0] f);
    check({tag, "_reg"}, {level_r, full_r, afull_r, empty_r, aempty_r, ovf_r, unf_r}, {lvl, f});
    check({tag, "_fwft"}, {level_f, full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f}, {lvl, f});
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0; clear_errors = 1'b0;
    step(); step();
    check_flags("reset", 3'd0, 6'b001100);
    check("reset_rdata", rdata_r, 8'h00);
    resetn = 1'b1;
    step();
    check_flags("idle", 3'd0, 6'b001100);

    // Fill to full, then a rejected fifth write
    wr_en = 1'b1;
    wr_data = 8'hA0; step(); check_flags("fill1", 3'd1, 6'b000100);
    check("fwft_head_a0", rdata_f, 8'hA0);
    wr_data = 8'hA1; step(); check_flags("fill2", 3'd2, 6'b000000);
    wr_data = 8'hA2; step(); check_flags("fill3", 3'd3, 6'b010000);
    wr_data = 8'hA3; step(); check_flags("fill4", 3'd4, 6'b110000);
    wr_data = 8'hA4; step(); check_flags("ovf", 3'd4, 6'b110010);
    wr_en = 1'b0;

    // Drain in order, then an underflowing fifth read
    rd_en = 1'b1;
    step(); check("drain0", rdata_r, 8'hA0); check("drain0_f", rdata_f, 8'hA1);
    check_flags("drain0", 3'd3, 6'b010010);
    step(); check("drain1", rdata_r, 8'hA1); check("drain1_f", rdata_f, 8'hA2);
    step(); check("drain2", rdata_r, 8'hA2); check("drain2_f", rdata_f, 8'hA3);
    check_flags("drain2", 3'd1, 6'b000110);
    step(); check("drain3", rdata_r, 8'hA3);
    check_flags("drain3", 3'd0, 6'b001110);
    step(); check("unf_hold", rdata_r, 8'hA3);
    check_flags("unf", 3'd0, 6'b001111);
    rd_en = 1'b0;
    clear_errors = 1'b1;
    step(); check_flags("clr", 3'd0, 6'b001100);
    clear_errors = 1'b0;

    // FWFT single word visible without a read
    wr_en = 1'b1; wr_data = 8'h55;
    step(); wr_en = 1'b0;
    check("fwft_55", rdata_f, 8'h55);
    check_flags("one_word", 3'd1, 6'b000100);
    rd_en = 1'b1;
    step(); rd_en = 1'b0;
    check_flags("pop55", 3'd0, 6'b001100);
    check("reg_55", rdata_r, 8'h55);

    // Steady level 2 with simultaneous push/pop across pointer wrap
    wr_en = 1'b1;
    wr_data = 8'h10; step();
    wr_data = 8'h11; step();
    rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_data = 8'(8'h12 + k);
      step();
      check($sformatf("stream_reg%0d", k), rdata_r, 8'(8'h10 + k));
      check($sformatf("stream_fwft%0d", k), rdata_f, 8'(8'h11 + k));
      check($sformatf("stream_lvl%0d", k), level_r, 3'd2);
    end
    rd_en = 1'b0;

    // Full with simultaneous write and read: only the read is accepted
    wr_data = 8'h20; step();
    wr_data = 8'h21; step();
    check_flags("refill", 3'd4, 6'b110000);
    rd_en = 1'b1; wr_data = 8'h22;
    step();
    check_flags("full_rw", 3'd3, 6'b010010);
    check("full_rw_data", rdata_r, 8'h1A);
    check("full_rw_head", rdata_f, 8'h1B);
    wr_en = 1'b0; rd_en = 1'b0; clear_errors = 1'b1;
    step(); clear_errors = 1'b0;
    check_flags("clr_ovf", 3'd3, 6'b010000);

    // Clear and a new error in the same cycle: set wins
    rd_en = 1'b1; clear_errors = 1'b1;
    step(); step(); step();
    check_flags("drain_to_empty", 3'd0, 6'b001100);
    step();
    check_flags("set_wins", 3'd0, 6'b001101);
    rd_en = 1'b0; clear_errors = 1'b0;

    // Asynchronous reset mid-operation at level 3
    wr_en = 1'b1;
    wr_data = 8'h30; step();
    wr_data = 8'h31; step();
    wr_data = 8'h32; step();
    wr_en = 1'b0;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    wr_en = 1'b1; wr_data = 8'h33; step(); wr_en = 1'b0;
    wr_en = 1'b1; wr_data = 8'h34; step(); wr_en = 1'b0;
    check_flags("pre_reset", 3'd4, 6'b110001);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check_flags("lvl3", 3'd3, 6'b010001);
    #2 resetn = 1'b0;
    #1;
    check_flags("async_rst", 3'd0, 6'b001100);
    check("async_rst_rdata", rdata_r, 8'h00);
    step();
    resetn = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77; step();
    check("post_rst_fwft", rdata_f, 8'h77);
    wr_data = 8'h78; step();
    wr_en = 1'b0;
    check_flags("post_rst_lvl", 3'd2, 6'b000000);
    rd_en = 1'b1;
    step(); check("post_rst_rd0", rdata_r, 8'h77);
    step(); check("post_rst_rd1", rdata_r, 8'h78);
    rd_en = 1'b0;
    check_flags("post_rst_empty", 3'd0, 6'b001100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_sync_thresh.md
FIFO_SYNC_THRESH -- requirements
Module: fifo_sync_thresh

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, level at or above which almost_full asserts; range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 2, level at or below which almost_empty asserts; range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port wr_data  in  DATA_WIDTH  write word.
REQ-009 SHALL have port wr_en  in  1  write request.
REQ-010 SHALL have port full  out  1  level == DEPTH.
REQ-011 SHALL have port almost_full  out  1  level >= AF_THRESH.
REQ-012 SHALL have port rd_en  in  1  read/pop request.
REQ-013 SHALL have port rd_data  out  DATA_WIDTH  read word.
REQ-014 SHALL have port empty  out  1  level == 0.
REQ-015 SHALL have port almost_empty  out  1  level <= AE_THRESH.
REQ-016 SHALL have port level  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port overflow  out  1  sticky: write attempted while full.
REQ-018 SHALL have port underflow  out  1  sticky: read attempted while empty.
REQ-019 SHALL have port clear_errors  in  1  synchronous clear of overflow/underflow.

Function
REQ-020 Write accepted iff wr_en && !full; word stored at write pointer, pointer increments mod DEPTH.
REQ-021 Read accepted iff rd_en && !empty; read pointer increments mod DEPTH.
REQ-022 full gates writes regardless of rd_en: write while full and reading SHALL be rejected (no pass-through).
REQ-023 empty gates reads regardless of wr_en: read while empty and writing SHALL be rejected; written word stored normally.
REQ-024 level: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-025 full, empty, almost_full, almost_empty SHALL be registered, reflecting level after the same edge that updates level (no extra cycle lag).
REQ-026 FWFT=0: on accepted read, rd_data SHALL present the head word one cycle later and hold until next accepted read.
REQ-027 FWFT=1: rd_data SHALL combinationally show the word at the read pointer whenever !empty; rd_en pops; value undefined-but-stable (last memory content) when empty.
REQ-028 Write to empty FIFO with FWFT=1: word visible on rd_data and empty=0 the cycle after the write edge.
REQ-029 Pointer wrap: after DEPTH accepted writes/reads pointers SHALL return to 0 without data corruption.
REQ-030 overflow SHALL set on wr_en && full; underflow on rd_en && empty; both hold until clear_errors.
REQ-031 clear_errors and a new error event in same cycle: set SHALL win.
REQ-032 Memory contents SHALL NOT be reset; only pointers, level, flags, rd_data.

Reset
REQ-033 While resetn=0: pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0 (FWFT=0), overflow=0, underflow=0.
REQ-034 Reset asserted mid-operation SHALL discard all contents immediately (asynchronously); first edge after deassertion behaves as empty FIFO.

Verification (DEPTH=4, AF_THRESH=3, AE_THRESH=1 unless stated)
REQ-035 Fill: write 0xA0..0xA3 on 4 cycles -> level 1,2,3,4; almost_empty drops at level 2; almost_full at 3; full at 4; 5th write 0xA4 rejected, overflow=1.
REQ-036 Drain FWFT=0: 4 reads -> rd_data 0xA0..0xA3 each one cycle after rd_en; 5th read -> underflow=1, rd_data holds 0xA3, level stays 0.
REQ-037 FWFT=1: single write 0x55 -> next cycle empty=0, rd_data=0x55 without rd_en; rd_en pops, empty=1.
REQ-038 Simultaneous wr_en/rd_en at level 2 for 10 cycles with incrementing data -> level constant 2, output order matches input order across pointer wrap.
REQ-039 Full + wr_en + rd_en -> read accepted, write rejected, level 3, overflow=1; then clear_errors with no new event -> overflow=0.
REQ-040 resetn pulsed low at level 3 -> immediately level=0, empty=1, flags cleared; next write/read sequence returns only post-reset data.
